// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into registered ALU operands behind a 2-entry skid buffer.
module alu_issue_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [WORD_SIZE-1:0] in_pc,
    input  logic [WORD_SIZE-1:0] in_rs1_val,
    input  logic [WORD_SIZE-1:0] in_rs2_val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_a,
    output logic [WORD_SIZE-1:0] out_b,
    output logic [2:0]           out_alu_operation,
    output logic                 out_alu_alt,
    output logic [4:0]           out_rd,
    output logic                 out_illegal
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [WORD_SIZE-1:0] a;
        logic [WORD_SIZE-1:0] b;
        logic [2:0]           op;
        logic                 alt;
        logic [4:0]           rd;
        logic                 ill;
    } entry_t;

    entry_t dec, main_q, main_d, skid_q, skid_d;
    logic main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic accept, consume, move;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        dec = '0;
        dec.rd = in_instr[11:7];
        dec.op = f3;
        case (in_instr[6:0])
            OPC_OP: begin
                dec.a = in_rs1_val;
                dec.b = in_rs2_val;
                dec.alt = f7[5];
                dec.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                dec.a = in_rs1_val;
                dec.b = (f3 == 3'b001 || f3 == 3'b101) ? {{(WORD_SIZE-5){1'b0}}, in_instr[24:20]}
                                                       : {{(WORD_SIZE-12){in_instr[31]}}, in_instr[31:20]};
                dec.alt = (f3 == 3'b101) && f7[5];
                dec.ill = (f3 == 3'b001) ? (f7 != 7'h00)
                        : (f3 == 3'b101) ? (f7 != 7'h00 && f7 != 7'h20) : 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.a = (in_instr[6:0] == OPC_AUIPC) ? in_pc : '0;
                dec.b = {in_instr[31:12], 12'b0};
                dec.op = 3'd0;
            end
            default: dec.ill = 1'b1;
        endcase
        if (dec.ill) begin
            dec.a = '0;
            dec.b = '0;
            dec.op = 3'd0;
            dec.alt = 1'b0;
        end
    end

    assign in_ready = !skid_v_q;
    assign accept   = in_valid && in_ready;
    assign consume  = main_v_q && out_ready;
    assign move     = !main_v_q || consume;

    // The skid is only ever occupied while main is, so a consume with a full skid refills main from it.
    always_comb begin
        main_v_d = !flush && (skid_v_q || !move || accept);
        skid_v_d = !flush && (skid_v_q ? !consume : (accept && !move));
        main_d   = skid_v_q ? (consume ? skid_q : main_q) : ((move && accept) ? dec : main_q);
        skid_d   = (!skid_v_q && accept && !move) ? dec : skid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign out_valid         = main_v_q;
    assign out_a             = main_q.a;
    assign out_b             = main_q.b;
    assign out_alu_operation = main_q.op;
    assign out_alu_alt       = main_q.alt;
    assign out_rd            = main_q.rd;
    assign out_illegal       = main_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
    logic clk = 1'b0, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, out_a, out_b;
    logic [2:0] out_alu_operation;
    logic out_alu_alt, out_illegal;
    logic [4:0] out_rd;
    int n_vec = 0, n_err = 0;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0] op;
        logic alt, ill;
        logic [4:0] rd;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_alu_operation(out_alu_operation), .out_alu_alt(out_alu_alt), .out_rd(out_rd),
        .out_illegal(out_illegal)
    );

    function automatic exp_t ref_dec(input logic [31:0] ins, pc, r1, r2);
        exp_t e;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic legal = 1'b1;
        e.a = 0; e.b = 0; e.op = f3; e.alt = 1'b0; e.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            e.a = r1; e.b = r2; e.alt = f7[5];
            legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        end else if (ins[6:0] == 7'h13) begin
            e.a = r1;
            e.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
            e.alt = (f3 == 5) && f7 == 7'h20;
            if (f3 == 1) legal = (f7 == 0);
            if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
        end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
            e.a = (ins[6:0] == 7'h17) ? pc : 0;
            e.b = ins & 32'hFFFF_F000;
            e.op = 0;
        end else legal = 1'b0;
        e.ill = !legal;
        if (!legal) begin e.a = 0; e.b = 0; e.op = 0; e.alt = 0; end
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r = $urandom;
        logic [6:0] opc, f7;
        int k = $urandom_range(0, 5);
        opc = (k == 0) ? 7'h33 : (k == 1 || k == 5) ? 7'h13 : (k == 2) ? 7'h37 : (k == 3) ? 7'h17 : r[6:0];
        f7 = ($urandom_range(0, 3) == 0) ? r[31:25] : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
        return {f7, r[24:7], opc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_a", out_a, q[0].a);
            check("out_b", out_b, q[0].b);
            check("out_op", 32'(out_alu_operation), 32'(q[0].op));
            check("out_alt", 32'(out_alu_alt), 32'(q[0].alt));
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
            check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, pc, r1, r2, input logic ordy, fl);
        logic acc, con;
        in_valid = v; in_instr = ins; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
        out_ready = ordy; flush = fl;
        acc = v && q.size() < 2;
        con = q.size() > 0 && ordy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(ins, pc, r1, r2));
        end
        #1 compare();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_a"}, out_a, 0);
        check({tag, "_b"}, out_b, 0);
        check({tag, "_op"}, 32'(out_alu_operation), 0);
        check({tag, "_alt"}, 32'(out_alu_alt), 0);
        check({tag, "_rd"}, 32'(out_rd), 0);
        check({tag, "_ill"}, 32'(out_illegal), 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0;
        in_rs1_val = 0; in_rs2_val = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        cycle(1, 32'h002081B3, 0, 5, 7, 1, 0);
        check("add_a", out_a, 5); check("add_b", out_b, 7); check("add_rd", 32'(out_rd), 3);
        cycle(1, 32'h402081B3, 0, 5, 7, 1, 0);
        check("sub_alt", 32'(out_alu_alt), 1);
        cycle(1, 32'hFFF00093, 0, 0, 0, 1, 0);
        check("addi_b", out_b, 32'hFFFF_FFFF); check("addi_rd", 32'(out_rd), 1);
        cycle(1, 32'h40335293, 0, 9, 0, 1, 0);
        check("srai_b", out_b, 3); check("srai_op", 32'(out_alu_operation), 5);
        check("srai_alt", 32'(out_alu_alt), 1);
        cycle(1, 32'h123450B7, 0, 0, 0, 1, 0);
        check("lui_a", out_a, 0); check("lui_b", out_b, 32'h1234_5000);
        cycle(1, 32'h12345097, 32'h100, 0, 0, 1, 0);
        check("auipc_a", out_a, 32'h100); check("auipc_b", out_b, 32'h1234_5000);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(1, 32'h00108133, 0, 11, 1, 0, 0);
        cycle(1, 32'h002101B3, 0, 22, 2, 0, 0);
        check("bp_in_ready", 32'(in_ready), 0);
        cycle(1, 32'h00318233, 0, 33, 3, 0, 0);
        check("bp_stable_a", out_a, 11);
        cycle(1, 32'h00318233, 0, 33, 3, 1, 0);
        check("bp_second_a", out_a, 22);
        cycle(1, 32'h00318233, 0, 33, 3, 1, 0);
        check("bp_third_a", out_a, 33);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(1, 32'h40009093, 0, 4, 4, 0, 0);
        check("slli_ill", 32'(out_illegal), 1); check("slli_a", out_a, 0);
        cycle(1, 32'h0000007F, 0, 4, 4, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("opc_ill", 32'(out_illegal), 1); check("opc_b", out_b, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(1, 32'h002081B3, 0, 1, 2, 0, 0);
        cycle(1, 32'h002081B3, 0, 3, 4, 0, 0);
        cycle(1, 32'h002081B3, 0, 5, 6, 0, 1);
        check("flush_valid", 32'(out_valid), 0); check("flush_ready", 32'(in_ready), 1);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(1, 32'h402081B3, 0, 1, 2, 0, 0);
        cycle(1, 32'h0000007F, 0, 3, 4, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
